// File: rtl/keycode_lane_judge_if.sv
// Signal bundle between the keycode/note-queue side (master) and the lane judge (slave).
interface keycode_lane_judge_if;
  logic        clear;
  logic [7:0]  keycode;
  logic [15:0] song_ms;
  logic [3:0]  head_valid;
  logic [63:0] head_time;
  logic [3:0]  head_pop;
  logic        judge_valid;
  logic [1:0]  judge_lane;
  logic [1:0]  judge_grade;
  logic [19:0] score;
  logic [9:0]  combo;
  logic [9:0]  max_combo;

  modport master (
    output clear, keycode, song_ms, head_valid, head_time,
    input  head_pop, judge_valid, judge_lane, judge_grade, score, combo, max_combo
  );

  modport slave (
    input  clear, keycode, song_ms, head_valid, head_time,
    output head_pop, judge_valid, judge_lane, judge_grade, score, combo, max_combo
  );
endinterface

// File: rtl/keycode_lane_judge.sv
// Rhythm-game judge: HID keycode -> four lanes, press edge detect, timing grade,
// score/combo bookkeeping. One lane is evaluated per cycle by a free-running scanner.
module keycode_lane_judge #(
  parameter int unsigned PERFECT_MS  = 30,
  parameter int unsigned GOOD_MS     = 80,
  parameter logic [7:0]  KEY0        = 8'h07,
  parameter logic [7:0]  KEY1        = 8'h09,
  parameter logic [7:0]  KEY2        = 8'h0D,
  parameter logic [7:0]  KEY3        = 8'h0E,
  parameter int unsigned PTS_PERFECT = 300,
  parameter int unsigned PTS_GOOD    = 100
) (
  input logic                 Clk,
  input logic                 Reset_h,
  keycode_lane_judge_if.slave jb
);

  localparam logic [16:0] PERF_LIM  = 17'(PERFECT_MS);
  localparam logic [16:0] GOOD_LIM  = 17'(GOOD_MS);
  localparam logic [19:0] SCORE_MAX = 20'd999999;
  localparam logic [9:0]  COMBO_MAX = 10'd1023;
  localparam logic [19:0] PTS_P     = 20'(PTS_PERFECT);
  localparam logic [19:0] PTS_G     = 20'(PTS_GOOD);

  function automatic logic [19:0] sat_score(input logic [19:0] s, input logic [19:0] pts);
    logic [20:0] sum;
    sum = {1'b0, s} + {1'b0, pts};
    return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[19:0];
  endfunction

  function automatic logic [9:0] sat_combo(input logic [9:0] c);
    return (c == COMBO_MAX) ? COMBO_MAX : c + 10'd1;
  endfunction

  logic [7:0]         kc_q;
  logic [3:0]         down, down_prev, press, pend, pend_nxt, lane_bit;
  logic [1:0]         lane_idx;
  logic [15:0]        head_sel;
  logic [16:0]        song_x, head_x, d;
  logic signed [17:0] diff;
  logic               hit_p, hit_g, miss, drop, hit;
  logic [9:0]         combo_inc;

  logic [3:0]  head_pop_q;
  logic        judge_valid_q;
  logic [1:0]  judge_lane_q, judge_grade_q;
  logic [19:0] score_q;
  logic [9:0]  combo_q, max_combo_q;

  // Decode, edge detect and evaluate the lane under the scanner
  always_comb begin
    down     = {kc_q == KEY3, kc_q == KEY2, kc_q == KEY1, kc_q == KEY0};
    press    = down & ~down_prev;
    lane_bit = 4'b0001 << lane_idx;
    head_sel = jb.head_time[{lane_idx, 4'h0} +: 16];
    song_x   = {1'b0, jb.song_ms};
    head_x   = {1'b0, head_sel};
    diff     = $signed({1'b0, song_x}) - $signed({1'b0, head_x});
    d        = diff[17] ? 17'(-diff) : diff[16:0];

    hit_p = 1'b0;
    hit_g = 1'b0;
    miss  = 1'b0;
    drop  = 1'b0;
    if (jb.head_valid[lane_idx]) begin
      if (pend[lane_idx] && (d <= PERF_LIM))                      hit_p = 1'b1;
      else if (pend[lane_idx] && (d <= GOOD_LIM))                 hit_g = 1'b1;
      else if (pend[lane_idx] && ((song_x + GOOD_LIM) < head_x))  drop  = 1'b1;
      else if (song_x > (head_x + GOOD_LIM))                      miss  = 1'b1;
    end else if (pend[lane_idx]) begin
      drop = 1'b1;
    end
    hit = hit_p | hit_g;

    // A press landing on the cycle its lane is cleared survives: set wins.
    pend_nxt  = (pend & ~((hit | drop) ? lane_bit : 4'b0000)) | press;
    combo_inc = sat_combo(combo_q);
  end

  // Register stage: keycode capture, pend state, judgment outputs
  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      lane_idx      <= 2'd0;
      kc_q          <= 8'h00;
      down_prev     <= 4'b0000;
      pend          <= 4'b0000;
      head_pop_q    <= 4'b0000;
      judge_valid_q <= 1'b0;
      judge_lane_q  <= 2'd0;
      judge_grade_q <= 2'b00;
      score_q       <= 20'd0;
      combo_q       <= 10'd0;
      max_combo_q   <= 10'd0;
    end else begin
      lane_idx <= lane_idx + 2'd1;
      if (jb.clear) begin
        kc_q          <= 8'h00;
        down_prev     <= 4'b0000;
        pend          <= 4'b0000;
        head_pop_q    <= 4'b0000;
        judge_valid_q <= 1'b0;
        judge_lane_q  <= 2'd0;
        judge_grade_q <= 2'b00;
        score_q       <= 20'd0;
        combo_q       <= 10'd0;
        max_combo_q   <= 10'd0;
      end else begin
        kc_q          <= jb.keycode;
        down_prev     <= down;
        pend          <= pend_nxt;
        head_pop_q    <= (hit | miss) ? lane_bit : 4'b0000;
        judge_valid_q <= hit | miss;
        judge_lane_q  <= (hit | miss) ? lane_idx : 2'd0;
        judge_grade_q <= hit_p ? 2'b01 : hit_g ? 2'b10 : miss ? 2'b11 : 2'b00;
        if (hit) begin
          score_q <= sat_score(score_q, hit_p ? PTS_P : PTS_G);
          combo_q <= combo_inc;
          if (combo_inc > max_combo_q) max_combo_q <= combo_inc;
        end else if (miss) begin
          combo_q <= 10'd0;
        end
      end
    end
  end

  assign jb.head_pop    = head_pop_q;
  assign jb.judge_valid = judge_valid_q;
  assign jb.judge_lane  = judge_lane_q;
  assign jb.judge_grade = judge_grade_q;
  assign jb.score       = score_q;
  assign jb.combo       = combo_q;
  assign jb.max_combo   = max_combo_q;

endmodule

// File: tb/tb_keycode_lane_judge.sv
// Bench for keycode_lane_judge: behavioural reference model checked every cycle,
// directed scenarios with literal expectations, then randomized play.
module tb_keycode_lane_judge;
  logic Clk = 1'b0;
  logic Reset_h = 1'b0;
  keycode_lane_judge_if jb();

  keycode_lane_judge dut (.Clk(Clk), .Reset_h(Reset_h), .jb(jb));

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state
  int m_scan, m_kq, m_prevlane, m_score, m_combo, m_max, m_grade, m_lane, m_pop;
  bit m_pend [4];

  logic [7:0] codes [6] = '{8'h00, 8'h07, 8'h09, 8'h0D, 8'h0E, 8'h2C};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lane_of(input int code);
    case (code)
      'h07: return 0;
      'h09: return 1;
      'h0D: return 2;
      'h0E: return 3;
      default: return -1;
    endcase
  endfunction

  // Behavioural model: one lane judged per cycle, lane = cycles since reset mod 4
  initial begin : model
    int L, cur, ht, sg, dd, grade;
    m_scan = 0; m_kq = 0; m_prevlane = -1; m_score = 0; m_combo = 0; m_max = 0;
    m_grade = 0; m_lane = 0; m_pop = 0;
    for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
    forever begin
      @(posedge Clk or posedge Reset_h);
      if (Reset_h) begin
        m_scan = 0; m_kq = 0; m_prevlane = -1; m_score = 0; m_combo = 0; m_max = 0;
        m_grade = 0; m_lane = 0; m_pop = 0;
        for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
      end else begin
        L = m_scan;
        if (jb.clear) begin
          m_kq = 0; m_prevlane = -1; m_score = 0; m_combo = 0; m_max = 0;
          m_grade = 0; m_lane = 0; m_pop = 0;
          for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
        end else begin
          cur   = lane_of(m_kq);
          grade = 0;
          ht    = int'(jb.head_time[16*L +: 16]);
          sg    = int'(jb.song_ms);
          dd    = (sg > ht) ? sg - ht : ht - sg;
          if (!jb.head_valid[L]) m_pend[L] = 1'b0;
          else if (m_pend[L] && dd <= 30) begin grade = 1; m_pend[L] = 1'b0; end
          else if (m_pend[L] && dd <= 80) begin grade = 2; m_pend[L] = 1'b0; end
          else if (m_pend[L] && sg + 80 < ht) m_pend[L] = 1'b0;
          else if (sg > ht + 80) grade = 3;
          if (cur >= 0 && cur != m_prevlane) m_pend[cur] = 1'b1;
          m_prevlane = cur;
          m_kq = int'(jb.keycode);
          if (grade == 1 || grade == 2) begin
            m_score = m_score + ((grade == 1) ? 300 : 100);
            if (m_score > 999999) m_score = 999999;
            if (m_combo < 1023) m_combo = m_combo + 1;
            if (m_combo > m_max) m_max = m_combo;
          end else if (grade == 3) begin
            m_combo = 0;
          end
          m_grade = grade;
          m_lane  = (grade != 0) ? L : 0;
          m_pop   = (grade != 0) ? (1 << L) : 0;
        end
        m_scan = (m_scan + 1) % 4;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  initial begin : compare
    forever begin
      @(negedge Clk);
      if (chk_en && !Reset_h) begin
        check("m_score",       int'(jb.score),       m_score);
        check("m_combo",       int'(jb.combo),       m_combo);
        check("m_max_combo",   int'(jb.max_combo),   m_max);
        check("m_judge_valid", int'(jb.judge_valid), (m_grade != 0) ? 1 : 0);
        check("m_judge_grade", int'(jb.judge_grade), m_grade);
        check("m_judge_lane",  int'(jb.judge_lane),  m_lane);
        check("m_head_pop",    int'(jb.head_pop),    m_pop);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic do_clear();
    jb.clear = 1'b1;
    tick();
    jb.clear = 1'b0;
  endtask

  task automatic set_head(input int lane, input int t);
    jb.head_time[16*lane +: 16] = 16'(t);
  endtask

  task automatic wait_judge(input int budget, output bit seen, output int lane,
                            output int grade, output int pop);
    seen = 1'b0; lane = -1; grade = -1; pop = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge Clk);
      #3;
      if (jb.judge_valid) begin
        seen  = 1'b1;
        lane  = int'(jb.judge_lane);
        grade = int'(jb.judge_grade);
        pop   = int'(jb.head_pop);
      end
    end
  endtask

  task automatic count_judges(input int cycles, output int n, output int mask);
    n = 0; mask = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge Clk);
      #3;
      if (jb.judge_valid) begin
        n++;
        mask = mask | (1 << int'(jb.judge_lane));
      end
    end
  endtask

  initial begin : stim
    bit seen;
    int lane, grade, pop, n, mask, song, budget;
    jb.clear = 1'b0; jb.keycode = 8'h00; jb.song_ms = 16'd0;
    jb.head_valid = 4'b0000; jb.head_time = 64'd0;

    #1 Reset_h = 1'b1;
    #3;
    check("rst_score", int'(jb.score), 0);
    check("rst_combo", int'(jb.combo), 0);
    check("rst_max", int'(jb.max_combo), 0);
    check("rst_judge_valid", int'(jb.judge_valid), 0);
    check("rst_head_pop", int'(jb.head_pop), 0);
    check("rst_grade", int'(jb.judge_grade), 0);
    repeat (2) @(posedge Clk);
    #2 Reset_h = 1'b0;
    chk_en = 1'b1;

    // Perfect hit on lane 0
    jb.head_valid = 4'b0001; set_head(0, 1000); jb.song_ms = 16'd1010; jb.keycode = 8'h07;
    wait_judge(6, seen, lane, grade, pop);
    check("perfect_seen", int'(seen), 1);
    check("perfect_lane", lane, 0);
    check("perfect_grade", grade, 1);
    check("perfect_pop", pop, 1);
    check("perfect_score", int'(jb.score), 300);
    check("perfect_combo", int'(jb.combo), 1);
    check("perfect_max", int'(jb.max_combo), 1);
    jb.keycode = 8'h00; jb.head_valid = 4'b0000;
    repeat (2) tick();

    // Good on lane 2, then a miss on the next head note
    do_clear();
    jb.head_valid = 4'b0100; set_head(2, 2000); jb.song_ms = 16'd2050; jb.keycode = 8'h0D;
    wait_judge(6, seen, lane, grade, pop);
    check("good_seen", int'(seen), 1);
    check("good_lane", lane, 2);
    check("good_grade", grade, 2);
    check("good_score", int'(jb.score), 100);
    check("good_combo", int'(jb.combo), 1);
    jb.keycode = 8'h00; set_head(2, 2100); jb.song_ms = 16'd2181;
    wait_judge(6, seen, lane, grade, pop);
    check("miss_seen", int'(seen), 1);
    check("miss_lane", lane, 2);
    check("miss_grade", grade, 3);
    check("miss_pop", pop, 4);
    check("miss_combo", int'(jb.combo), 0);
    check("miss_max", int'(jb.max_combo), 1);
    check("miss_score", int'(jb.score), 100);
    jb.head_valid = 4'b0000;
    tick();

    // Early tap: pend dropped, so a later on-time moment gives nothing
    do_clear();
    jb.head_valid = 4'b1000; set_head(3, 5000); jb.song_ms = 16'd4900; jb.keycode = 8'h0E;
    count_judges(8, n, mask);
    check("early_no_judge", n, 0);
    check("early_score", int'(jb.score), 0);
    jb.keycode = 8'h00; jb.song_ms = 16'd5000;
    count_judges(8, n, mask);
    check("early_pend_dropped", n, 0);
    jb.head_valid = 4'b0000;

    // Ghost tap: no head, pend must be gone before a head appears
    do_clear();
    jb.keycode = 8'h09; tick(); tick(); jb.keycode = 8'h00;
    count_judges(8, n, mask);
    check("ghost_no_judge", n, 0);
    jb.head_valid = 4'b0010; set_head(1, 5000);
    count_judges(8, n, mask);
    check("ghost_pend_dropped", n, 0);
    jb.head_valid = 4'b0000;

    // Burst of perfect hits to approach score/combo saturation
    do_clear();
    jb.song_ms = 16'd1234;
    for (int l = 0; l < 4; l++) set_head(l, 1234);
    jb.head_valid = 4'b1111;
    budget = 0;
    while (jb.score < 20'd999900 && budget < 5000) begin
      jb.keycode = codes[1 + (budget % 4)];
      tick();
      budget++;
    end
    check("burst_reached", (jb.score >= 20'd999900) ? 1 : 0, 1);
    jb.keycode = 8'h00;
    repeat (8) tick();
    jb.keycode = 8'h07; tick();
    jb.keycode = 8'h0E; tick();
    jb.keycode = 8'h00;
    count_judges(10, n, mask);
    check("dual_count", n, 2);
    check("dual_lanes", mask, 9);
    check("sat_score", int'(jb.score), 999999);
    check("sat_combo", int'(jb.combo), 1023);
    check("sat_max", int'(jb.max_combo), 1023);

    // Clear mid-play with all lanes pending
    do_clear();
    jb.keycode = 8'h07; tick(); jb.keycode = 8'h09; tick(); jb.keycode = 8'h00;
    repeat (8) tick();
    check("pre_clear_score", int'(jb.score), 600);
    jb.keycode = 8'h07; tick(); jb.keycode = 8'h09; tick();
    jb.keycode = 8'h0D; tick(); jb.keycode = 8'h0E; tick();
    jb.keycode = 8'h00; jb.clear = 1'b1; tick(); jb.clear = 1'b0;
    check("clr_score", int'(jb.score), 0);
    check("clr_combo", int'(jb.combo), 0);
    check("clr_max", int'(jb.max_combo), 0);
    check("clr_judge_valid", int'(jb.judge_valid), 0);
    count_judges(8, n, mask);
    check("clr_pend_gone", n, 0);
    jb.head_valid = 4'b0000;

    // Randomized play
    song = 300;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) jb.keycode = codes[$urandom_range(0, 5)];
      song = song + int'($urandom_range(0, 4));
      if (song > 60000) song = 300;
      jb.song_ms = 16'(song);
      if ($urandom_range(0, 7) == 0) begin
        jb.head_valid = 4'($urandom_range(0, 15));
        for (int l = 0; l < 4; l++) set_head(l, song + int'($urandom_range(0, 300)) - 150);
      end
      jb.clear = ($urandom_range(0, 299) == 0);
      tick();
    end
    jb.clear = 1'b0; jb.keycode = 8'h00;

    // Short asynchronous reset pulse after some scoring
    do_clear();
    jb.head_valid = 4'b1111; jb.song_ms = 16'd3000;
    for (int l = 0; l < 4; l++) set_head(l, 3000);
    jb.keycode = 8'h07; tick(); jb.keycode = 8'h09; tick(); jb.keycode = 8'h00;
    repeat (8) tick();
    check("pre_rst_score", int'(jb.score), 600);
    Reset_h = 1'b1;
    #1;
    check("arst_score", int'(jb.score), 0);
    check("arst_combo", int'(jb.combo), 0);
    check("arst_max", int'(jb.max_combo), 0);
    check("arst_judge_valid", int'(jb.judge_valid), 0);
    check("arst_head_pop", int'(jb.head_pop), 0);
    #1 Reset_h = 1'b0;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
